// File: rtl/sio_remote.sv
// sio_remote -- remote end of a nibble-wide half-duplex serial link.
//
// A host frame is a 0 start nibble, 24 data nibbles (80-bit payload then a
// 16-bit stream word, LSB nibble first) and 4 CRC-16/USB nibbles. A frame
// with a good CRC raises a read or write strobe and, after REPLY_GAP idle
// cycles, is answered with a preamble nibble (F), the stream_out word,
// a 32-bit data field and a CRC-16/USB over those 12 nibbles.
//
// Ports:
//   c             clock (rising edge)
//   rst_n         asynchronous active-low reset
//   rd            nibble sampled from the line (idle line reads 4'hF)
//   td / tq       nibble to drive / drive enable
//   stream_out    stream word returned in each reply
//   stream_in     stream word of the last frame with a good CRC
//   wr / rdreq    one-cycle write / read strobes
//   addr / wdata  address and data of the last frame with a good CRC
//   rdata         read data returned in the reply of a read frame
//   crc_failcount saturating count of frames with a bad CRC
//
// Build option: define SIO_REMOTE_CRCCOUNT_EN to build the CRC failure
// counter; otherwise crc_failcount is tied to 0.

// One nibble step of reflected CRC-16/USB (poly 0x8005, reflected 0xA001).
// Combinational; the caller owns the init value (FFFF) and final inversion.
module crc_16_4_usb (
  input  logic [15:0] i_crc,
  input  logic [3:0]  i_nib,
  output logic [15:0] o_crc
);
  always_comb begin
    o_crc = i_crc ^ {12'h000, i_nib};
    for (int i = 0; i < 4; i++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ 16'hA001) : (o_crc >> 1);
    end
  end
endmodule

module sio_remote #(
  parameter int REPLY_GAP = 4
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic [3:0]  rd,
  output logic [3:0]  td,
  output logic        tq,
  input  logic [15:0] stream_out,
  output logic [15:0] stream_in,
  output logic        wr,
  output logic        rdreq,
  output logic [9:0]  addr,
  output logic [63:0] wdata,
  input  logic [31:0] rdata,
  output logic [15:0] crc_failcount
);

  typedef enum logic [2:0] {IDLE, RXD, RXC, GAP, TXS, TXD, TXC} state_t;

  localparam logic [4:0] GAP_LEN = 5'(REPLY_GAP);

  state_t      r_state;
  // RX/GAP: cycles elapsed in the phase; TX phases: nibbles already driven.
  logic [4:0]  r_cnt;
  logic [95:0] r_sh;        // {stream, payload} after 24 nibbles
  logic [11:0] r_rcrc;      // first three received CRC nibbles
  logic [15:0] r_rx_crc;
  logic [15:0] r_tx_crc;
  logic [27:0] r_tx_sh;     // nibbles still to drive in the current TX phase
  logic        r_is_read;
  logic [3:0]  r_td;
  logic        r_tq;
  logic        r_wr;
  logic        r_rdreq;
  logic [15:0] r_stream_in;
  logic [9:0]  r_addr;
  logic [63:0] r_wdata;

  logic [15:0] w_rx_crc_nxt;
  logic [15:0] w_rx_crc_got;
  logic        w_crc_ok;
  logic [31:0] w_field;
  logic [3:0]  w_tx_nib;
  logic [15:0] w_tx_crc_in;
  logic [15:0] w_tx_crc_nxt;

  crc_16_4_usb u_rx_crc (
    .i_crc (r_rx_crc),
    .i_nib (rd),
    .o_crc (w_rx_crc_nxt)
  );

  // The last CRC nibble is still on rd in the deciding cycle.
  assign w_rx_crc_got = {rd, r_rcrc};
  assign w_crc_ok     = (w_rx_crc_got == ~r_rx_crc);
  assign w_field      = r_is_read ? rdata : 32'hFFFF_FFFF;

  // Next data nibble to drive: first stream nibble leaving GAP, first
  // field nibble leaving TXS, otherwise the head of the TX shifter.
  always_comb begin
    w_tx_nib = r_tx_sh[3:0];
    if (r_state == GAP) begin
      w_tx_nib = stream_out[3:0];
    end else if (r_state == TXS && r_cnt == 5'd4) begin
      w_tx_nib = w_field[3:0];
    end
  end

  assign w_tx_crc_in = (r_state == GAP) ? 16'hFFFF : r_tx_crc;

  crc_16_4_usb u_tx_crc (
    .i_crc (w_tx_crc_in),
    .i_nib (w_tx_nib),
    .o_crc (w_tx_crc_nxt)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_sh        <= '0;
      r_rcrc      <= '0;
      r_rx_crc    <= 16'hFFFF;
      r_tx_crc    <= 16'hFFFF;
      r_tx_sh     <= '0;
      r_is_read   <= 1'b0;
      r_td        <= 4'hF;
      r_tq        <= 1'b0;
      r_wr        <= 1'b0;
      r_rdreq     <= 1'b0;
      r_stream_in <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_wr    <= 1'b0;
      r_rdreq <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tq <= 1'b0;
          r_td <= 4'hF;
          if (rd == 4'h0) begin
            r_state  <= RXD;
            r_cnt    <= 5'd0;
            r_rx_crc <= 16'hFFFF;
          end
        end
        RXD: begin
          r_sh     <= {rd, r_sh[95:4]};
          r_rx_crc <= w_rx_crc_nxt;
          if (r_cnt == 5'd23) begin
            r_state <= RXC;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        RXC: begin
          r_rcrc <= {rd, r_rcrc[11:4]};
          if (r_cnt == 5'd3) begin
            if (w_crc_ok) begin
              r_stream_in <= r_sh[95:80];
              r_addr      <= r_sh[73:64];
              r_wdata     <= r_sh[63:0];
              r_is_read   <= ~r_sh[79];
              r_rdreq     <= ~r_sh[79];
              // An all-ones payload is a no-op: reply without a strobe.
              r_wr        <= r_sh[79] & ~(&r_sh[79:0]);
              r_state     <= GAP;
              r_cnt       <= 5'd1;
              r_tq        <= (GAP_LEN == 5'd1);
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LEN) begin
            r_state  <= TXS;
            r_td     <= w_tx_nib;
            r_tx_sh  <= {16'h0000, stream_out[15:4]};
            r_tx_crc <= w_tx_crc_nxt;
            r_cnt    <= 5'd1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            // Preamble: drive F on the last gap cycle.
            if (r_cnt + 5'd1 == GAP_LEN) begin
              r_tq <= 1'b1;
            end
          end
        end
        TXS: begin
          r_td     <= w_tx_nib;
          r_tx_crc <= w_tx_crc_nxt;
          if (r_cnt == 5'd4) begin
            r_state <= TXD;
            r_tx_sh <= w_field[31:4];
            r_cnt   <= 5'd1;
          end else begin
            r_tx_sh <= r_tx_sh >> 4;
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        TXD: begin
          if (r_cnt == 5'd8) begin
            r_state <= TXC;
            r_td    <= ~r_tx_crc[3:0];
            r_tx_sh <= {16'h0000, ~r_tx_crc[15:4]};
            r_cnt   <= 5'd1;
          end else begin
            r_td     <= w_tx_nib;
            r_tx_crc <= w_tx_crc_nxt;
            r_tx_sh  <= r_tx_sh >> 4;
            r_cnt    <= r_cnt + 5'd1;
          end
        end
        TXC: begin
          if (r_cnt == 5'd4) begin
            r_state <= IDLE;
            r_tq    <= 1'b0;
            r_td    <= 4'hF;
          end else begin
            r_td    <= r_tx_sh[3:0];
            r_tx_sh <= r_tx_sh >> 4;
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tq    <= 1'b0;
          r_td    <= 4'hF;
        end
      endcase
    end
  end

`ifdef SIO_REMOTE_CRCCOUNT_EN
  logic [15:0] r_crc_failcount;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_failcount <= '0;
    end else if (r_state == RXC && r_cnt == 5'd3 && !w_crc_ok &&
                 r_crc_failcount != 16'hFFFF) begin
      r_crc_failcount <= r_crc_failcount + 16'd1;
    end
  end

  assign crc_failcount = r_crc_failcount;
`else
  assign crc_failcount = 16'h0000;
`endif

  assign td        = r_td;
  assign tq        = r_tq;
  assign wr        = r_wr;
  assign rdreq     = r_rdreq;
  assign stream_in = r_stream_in;
  assign addr      = r_addr;
  assign wdata     = r_wdata;

endmodule

// File: tb/tb_sio_remote.sv
// Bench for sio_remote: three instances (REPLY_GAP 4, 1, 15) share the line
// inputs. Expected reply nibbles for the REPLY_GAP=4 instance are pushed to
// exp_q when a frame is sent and popped as the reply appears on td.
module tb_sio_remote;

  logic        c;
  logic        rst_n;
  logic [3:0]  rd;
  logic [15:0] stream_out;
  logic [31:0] rdata;

  logic [2:0]  tq_a, wr_a, rdreq_a;
  logic [3:0]  td_a [3];
  logic [15:0] sin_a [3];
  logic [15:0] fail_a [3];
  logic [9:0]  addr_a [3];
  logic [63:0] wdata_a [3];

  int gaps [3] = '{4, 1, 15};

  logic [3:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  // Model of the registered outputs of the main instance.
  logic [15:0] m_sin;
  logic [9:0]  m_addr;
  logic [63:0] m_wdata;
  logic [15:0] m_fail;

  sio_remote #(.REPLY_GAP(4)) u_dut (
    .c(c), .rst_n(rst_n), .rd(rd), .td(td_a[0]), .tq(tq_a[0]),
    .stream_out(stream_out), .stream_in(sin_a[0]), .wr(wr_a[0]),
    .rdreq(rdreq_a[0]), .addr(addr_a[0]), .wdata(wdata_a[0]),
    .rdata(rdata), .crc_failcount(fail_a[0])
  );

  sio_remote #(.REPLY_GAP(1)) u_g1 (
    .c(c), .rst_n(rst_n), .rd(rd), .td(td_a[1]), .tq(tq_a[1]),
    .stream_out(stream_out), .stream_in(sin_a[1]), .wr(wr_a[1]),
    .rdreq(rdreq_a[1]), .addr(addr_a[1]), .wdata(wdata_a[1]),
    .rdata(rdata), .crc_failcount(fail_a[1])
  );

  sio_remote #(.REPLY_GAP(15)) u_g15 (
    .c(c), .rst_n(rst_n), .rd(rd), .td(td_a[2]), .tq(tq_a[2]),
    .stream_out(stream_out), .stream_in(sin_a[2]), .wr(wr_a[2]),
    .rdreq(rdreq_a[2]), .addr(addr_a[2]), .wdata(wdata_a[2]),
    .rdata(rdata), .crc_failcount(fail_a[2])
  );

  // Clock
  initial c = 1'b0;
  always #5 c = ~c;

  // Bit-serial reflected CRC-16/USB reference, one nibble LSB first.
  function automatic logic [15:0] crc_nib(input logic [15:0] cin, input logic [3:0] n);
    logic [15:0] cc;
    logic        fb;
    cc = cin;
    for (int i = 0; i < 4; i++) begin
      fb = cc[0] ^ n[i];
      cc = cc >> 1;
      if (fb) cc = cc ^ 16'hA001;
    end
    return cc;
  endfunction

  // Push the 16 expected data/CRC nibbles of a reply.
  task automatic push_reply(input logic [15:0] st, input logic [31:0] field);
    logic [47:0] w;
    logic [15:0] cc;
    w  = {field, st};
    cc = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(w[i*4 +: 4]);
      cc = crc_nib(cc, w[i*4 +: 4]);
    end
    cc = ~cc;
    for (int i = 0; i < 4; i++) exp_q.push_back(cc[i*4 +: 4]);
  endtask

  // Drive start nibble, 24 data nibbles and 4 CRC nibbles; flip corrupts one CRC bit.
  task automatic send_frame(input logic [79:0] pl, input logic [15:0] st, input bit flip);
    logic [95:0] f;
    logic [15:0] cc;
    f  = {st, pl};
    cc = 16'hFFFF;
    @(negedge c) rd = 4'h0;
    for (int i = 0; i < 24; i++) begin
      @(negedge c) rd = f[i*4 +: 4];
      cc = crc_nib(cc, f[i*4 +: 4]);
    end
    cc = ~cc;
    if (flip) cc[5] = ~cc[5];
    for (int i = 0; i < 4; i++) begin
      @(negedge c) rd = cc[i*4 +: 4];
    end
  endtask

  // Observe 50 cycles after the last CRC nibble and check strobes,
  // held registers, reply timing and reply nibbles.
  task automatic collect(input string name, input bit exp_reply, input bit exp_wr,
                         input bit exp_rd, input bit noise);
    int first [3];
    int tq_cnt [3];
    int td_bad [3];
    int wr_cnt, rd_cnt;
    logic [3:0] nib;
    for (int k = 0; k < 3; k++) begin
      first[k] = -1; tq_cnt[k] = 0; td_bad[k] = 0;
    end
    wr_cnt = 0; rd_cnt = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge c);
      rd = (noise && j >= 2 && j <= 15) ? 4'h0 : 4'hF;
      wr_cnt += int'(wr_a[0]);
      rd_cnt += int'(rdreq_a[0]);
      if (j == 0) begin
        total++;
        if (wr_a[0] !== exp_wr || rdreq_a[0] !== exp_rd) begin
          bad++;
          $display("FAIL %s strobe: wr=%0b rdreq=%0b want wr=%0b rdreq=%0b",
                   name, wr_a[0], rdreq_a[0], exp_wr, exp_rd);
        end
        total++;
        if (sin_a[0] !== m_sin || addr_a[0] !== m_addr || wdata_a[0] !== m_wdata) begin
          bad++;
          $display("FAIL %s regs: sin=%h addr=%h wdata=%h want sin=%h addr=%h wdata=%h",
                   name, sin_a[0], addr_a[0], wdata_a[0], m_sin, m_addr, m_wdata);
        end
        total++;
        if (fail_a[0] !== m_fail) begin
          bad++;
          $display("FAIL %s crc_failcount: got %0d want %0d", name, fail_a[0], m_fail);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (tq_a[k] === 1'b1) begin
          if (first[k] < 0) begin
            first[k] = j;
            total++;
            if (td_a[k] !== 4'hF) begin
              bad++;
              $display("FAIL %s preamble[%0d]: td=%h want f", name, k, td_a[k]);
            end
          end else if (k == 0) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL %s reply: extra nibble %h, none expected", name, td_a[0]);
            end else begin
              nib = exp_q.pop_front();
              if (td_a[0] !== nib) begin
                bad++;
                $display("FAIL %s reply nibble %0d: got %h want %h",
                         name, tq_cnt[0] - 1, td_a[0], nib);
              end
            end
          end else if (j == first[k] + 1) begin
            total++;
            if (td_a[k] !== stream_out[3:0]) begin
              bad++;
              $display("FAIL %s first nibble[%0d]: got %h want %h",
                       name, k, td_a[k], stream_out[3:0]);
            end
          end
          tq_cnt[k]++;
        end else if (td_a[k] !== 4'hF) begin
          td_bad[k]++;
        end
      end
    end
    total++;
    if (wr_cnt != int'(exp_wr) || rd_cnt != int'(exp_rd)) begin
      bad++;
      $display("FAIL %s strobe count: wr=%0d rdreq=%0d want %0d %0d",
               name, wr_cnt, rd_cnt, exp_wr, exp_rd);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (tq_cnt[k] != (exp_reply ? 17 : 0)) begin
        bad++;
        $display("FAIL %s tq cycles[%0d]: got %0d want %0d",
                 name, k, tq_cnt[k], exp_reply ? 17 : 0);
      end
      if (exp_reply) begin
        total++;
        if (first[k] != gaps[k] - 1) begin
          bad++;
          $display("FAIL %s latency[%0d]: preamble at %0d want %0d",
                   name, k, first[k], gaps[k] - 1);
        end
      end
      total++;
      if (td_bad[k] != 0) begin
        bad++;
        $display("FAIL %s td idle[%0d]: %0d cycles not f with tq=0 want 0",
                 name, k, td_bad[k]);
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s reply: %0d nibbles missing want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Good frame: update the model, push the reply, send and collect.
  task automatic good_frame(input string name, input logic [79:0] pl,
                            input logic [15:0] st, input bit noise);
    bit is_rd, is_wr;
    is_rd   = ~pl[79];
    is_wr   = pl[79] & ~(&pl);
    m_sin   = st;
    m_addr  = pl[73:64];
    m_wdata = pl[63:0];
    push_reply(stream_out, is_rd ? rdata : 32'hFFFF_FFFF);
    send_frame(pl, st, 1'b0);
    collect(name, 1'b1, is_wr, is_rd, noise);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    rd = 4'hF;
    stream_out = 16'h0;
    rdata = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tq_a !== 3'b000 || td_a[0] !== 4'hF || wr_a[0] !== 1'b0 || rdreq_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset line: tq=%b td=%h wr=%b rdreq=%b want 000 f 0 0",
               tq_a, td_a[0], wr_a[0], rdreq_a[0]);
    end
    total++;
    if (sin_a[0] !== 16'h0 || addr_a[0] !== 10'h0 || wdata_a[0] !== 64'h0 ||
        fail_a[0] !== 16'h0) begin
      bad++;
      $display("FAIL reset regs: sin=%h addr=%h wdata=%h fail=%h want zeros",
               sin_a[0], addr_a[0], wdata_a[0], fail_a[0]);
    end
    m_sin = '0; m_addr = '0; m_wdata = '0; m_fail = '0;
    repeat (3) @(negedge c);
    rst_n = 1'b1;
    repeat (2) @(negedge c);
  endtask

  task automatic test_write;
    stream_out = 16'h1357;
    rdata = 32'h1111_2222;
    good_frame("write", {1'b1, 5'b0, 10'h001, 64'h0123_4567_89AB_CDEF}, 16'hBEEF, 1'b0);
  endtask

  task automatic test_read;
    stream_out = 16'h1234;
    rdata = 32'hCAFE_F00D;
    good_frame("read", {1'b0, 5'b0, 10'h2A5, 64'hDEAD_0000_BEEF_0001}, 16'h4242, 1'b0);
  endtask

  task automatic test_bad_crc;
    stream_out = 16'h7777;
`ifdef SIO_REMOTE_CRCCOUNT_EN
    m_fail = m_fail + 16'd1;
`endif
    send_frame({1'b1, 5'b0, 10'h155, 64'hAAAA_5555_AAAA_5555}, 16'h9999, 1'b1);
    collect("bad_crc", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_noop;
    stream_out = 16'hA5C3;
    rdata = 32'h0BAD_0BAD;
    good_frame("noop", {80{1'b1}}, 16'h5A5A, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge c) rd = 4'h0;
    for (int i = 0; i < 9; i++) begin
      @(negedge c) rd = 4'(i + 1);
    end
    @(negedge c) rd = 4'h6;
    rst_n = 1'b0;
    #1;
    total++;
    if (tq_a !== 3'b000 || sin_a[0] !== 16'h0 || fail_a[0] !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: tq=%b sin=%h fail=%h want 000 0000 0000",
               tq_a, sin_a[0], fail_a[0]);
    end
    m_sin = '0; m_addr = '0; m_wdata = '0; m_fail = '0;
    @(negedge c) rd = 4'hF;
    @(negedge c) rst_n = 1'b1;
    @(negedge c);
    stream_out = 16'hC0DE;
    rdata = 32'h8765_4321;
    good_frame("after_reset", {1'b0, 5'b0, 10'h3FF, 64'h0F0F_0F0F_F0F0_F0F0}, 16'h0042, 1'b0);
  endtask

  // Frames sent back to back; some with 0 nibbles on the line during the reply.
  task automatic test_back_to_back;
    logic [79:0] pl;
    for (int n = 0; n < 4; n++) begin
      pl = {16'(($urandom_range(0, 65535))), 32'($urandom), 32'($urandom)};
      stream_out = 16'($urandom_range(0, 65535));
      rdata = 32'($urandom);
      good_frame("b2b", pl, 16'($urandom_range(0, 65535)), n[0]);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_bad_crc;
    test_noop;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sio_remote.md
SIO_REMOTE -- requirements
Module: sio_remote

Interface
REQ-001 SHALL have parameter REPLY_GAP, default 4, idle cycles between the last received CRC nibble and the first reply nibble; legal range 1..15.
REQ-002 SHALL have port c, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port rd, input, 4, the nibble sampled from the line by the external IO cell; an undriven line reads 4'hF.
REQ-005 SHALL have port td, output, 4, the nibble to drive onto the line.
REQ-006 SHALL have port tq, output, 1, line drive enable; 1 means drive td.
REQ-007 SHALL have port stream_out, input, 16, the stream word returned in each reply.
REQ-008 SHALL have port stream_in, output, 16, the last stream word received with a good CRC.
REQ-009 SHALL have port wr, output, 1, a one-cycle write strobe.
REQ-010 SHALL have port rdreq, output, 1, a one-cycle read strobe.
REQ-011 SHALL have port addr, output, 10, the frame address, taken from payload bits [73:64].
REQ-012 SHALL have port wdata, output, 64, the frame data, taken from payload bits [63:0].
REQ-013 SHALL have port rdata, input, 32, the read data returned in the reply.
REQ-014 SHALL have port crc_failcount, output, 16, the count of received frames that failed CRC.

Function
REQ-015 SHALL use the FSM states IDLE, RXD, RXC, GAP, TXS, TXD and TXC.
REQ-016 IDLE: when rd==0 in IDLE, the FSM SHALL go to RXD; any other rd value SHALL leave it in IDLE.
REQ-017 RXD SHALL shift in 24 nibbles, LSB nibble first: 20 payload nibbles (80 bits), then 4 stream nibbles; it then goes to RXC.
REQ-018 RXC SHALL shift in 4 CRC nibbles, LSB nibble first.
REQ-019 Received CRC SHALL be CRC-16/USB over the 24 RXD nibbles, computed by the crc_16_4_usb instance; the start nibble is excluded.
REQ-020 Good CRC, cycle after the last CRC nibble:
- stream_in SHALL update.
- addr and wdata SHALL update.
- If payload[79]==0, rdreq SHALL pulse.
- Else if payload != all-ones, wr SHALL pulse.
- An all-ones payload is a no-op; the reply is still sent.
- FSM SHALL go to GAP.
REQ-021 Bad CRC: there SHALL be no strobe, stream_in SHALL hold, crc_failcount SHALL increment, the FSM SHALL return to IDLE and no reply SHALL be sent.
REQ-022 GAP SHALL last REPLY_GAP cycles with tq=0; on its last cycle tq SHALL rise with td=4'hF (preamble).
REQ-023 TXS SHALL drive stream_out in 4 nibbles, LSB first; stream_out SHALL be sampled on the first TXS cycle.
REQ-024 TXD SHALL drive the 32-bit rdata field in 8 nibbles, LSB first.
REQ-025 For a read frame, the rdata field SHALL be rdata sampled on the first TXD cycle; the requester has REPLY_GAP+4 cycles from rdreq.
REQ-026 For a write or no-op frame, the rdata field SHALL be 32'hFFFFFFFF.
REQ-027 TXC SHALL drive a CRC-16/USB over the 12 TXS+TXD nibbles, LSB nibble first, then deassert tq and return to IDLE.
REQ-028 tq SHALL be 1 only from the GAP preamble cycle to the end of TXC; there are exactly 17 driven cycles.
REQ-029 td SHALL be 4'hF whenever tq=0.
REQ-030 Received frame to reply start latency SHALL be 28 + REPLY_GAP cycles after the start nibble.
REQ-031 A 0 nibble arriving during the GAP or TX states SHALL be ignored; no resync mid-reply.
REQ-032 crc_failcount SHALL saturate at 16'hFFFF.

Reset
REQ-033 While rst_n=0, all of the following SHALL hold immediately (asynchronous):
- FSM = IDLE
- tq = 0
- td = 4'hF
- wr = 0, rdreq = 0
- stream_in = 0, addr = 0, wdata = 0
- crc_failcount = 0
REQ-034 Reset mid-frame SHALL discard the partial frame; the first 0 nibble after release starts a new frame.

Configuration
REQ-035 When macro SIO_REMOTE_CRCCOUNT_EN is defined, crc_failcount SHALL count per REQ-021 and REQ-032.
REQ-036 When SIO_REMOTE_CRCCOUNT_EN is undefined, crc_failcount SHALL be constant 0 and no counter register SHALL exist; all other behaviour is unchanged.

Verification
REQ-037 Write frame, payload[79]=1, addr=10'h001, wdata=64'h0123456789ABCDEF, stream=16'hBEEF, good CRC -> one wr pulse with those values; stream_in=16'hBEEF; reply rdata field 32'hFFFFFFFF; host-side CRC check passes.
REQ-038 Read frame, addr=10'h2A5, rdata held at 32'hCAFEF00D -> one rdreq pulse; reply nibbles in order: stream_out LSB first, then D,0,0,F,E,F,A,C; valid CRC; tq high for exactly 17 cycles.
REQ-039 Frame with one flipped CRC bit -> no wr/rdreq, tq stays 0, stream_in unchanged, crc_failcount increments 0 -> 1 (stays 0 with the macro undefined).
REQ-040 All-ones payload frame -> no strobe; reply still sent.
REQ-041 rst_n pulled low on the 10th RXD nibble -> tq=0 at once; next valid frame after release is accepted normally.
REQ-042 REPLY_GAP=1 and REPLY_GAP=15 -> first reply nibble at 29 and 43 cycles after the start nibble, respectively.
